// File: rtl/spi_ram_param_if.sv
// Command/response bundle between the SPI slave front-end (master) and the RAM back-end (slave).
// din carries {cmd[1:0], payload}; dout/tx_valid/err return on the cycle after the command.
interface spi_ram_param_if #(
    parameter int ADDR_SIZE = 8
);
    logic [ADDR_SIZE+1:0] din;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] dout;
    logic                 tx_valid;
    logic                 err;

    modport master (output din, rx_valid, input dout, tx_valid, err);
    modport slave  (input din, rx_valid, output dout, tx_valid, err);
endinterface

// File: rtl/spi_ram_param.sv
// Parametrised single-port RAM behind the SPI slave: 2-bit command decode, optional burst auto-increment, err on rejected commands.
// Read data, tx_valid and err follow the command edge by one cycle; no backpressure, rx_valid gates every action.
module spi_ram_param #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256,
    parameter bit AUTO_INC  = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    spi_ram_param_if.slave bus
);
    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_t;

    // One extra bit so MEM_DEPTH == 2**ADDR_SIZE is representable and the range check is always true.
    localparam logic [ADDR_SIZE:0]   DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST  = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [ADDR_SIZE-1:0] payload;
    logic                 wr_armed;
    logic                 rd_armed;
    logic                 in_range;
    cmd_t                 cmd;

    assign cmd      = cmd_t'(bus.din[ADDR_SIZE+1:ADDR_SIZE]);
    assign payload  = bus.din[ADDR_SIZE-1:0];
    assign in_range = {1'b0, payload} < DEPTH;

    function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
        if (!AUTO_INC) begin
            return p;
        end
        return (p == LAST) ? '0 : p + ADDR_SIZE'(1);
    endfunction

    // Contents survive reset; only the armed flags stop stale bursts.
    always_ff @(posedge clk) begin
        if (bus.rx_valid && cmd == WR_DATA && wr_armed) begin
            mem[wr_ptr] <= payload;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dout     <= '0;
            bus.tx_valid <= 1'b0;
            bus.err      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wr_armed     <= 1'b0;
            rd_armed     <= 1'b0;
        end else begin
            bus.tx_valid <= 1'b0;
            bus.err      <= 1'b0;
            if (bus.rx_valid) begin
                case (cmd)
                    WR_ADDR: begin
                        if (in_range) begin
                            wr_ptr   <= payload;
                            wr_armed <= 1'b1;
                        end else begin
                            wr_armed <= 1'b0;
                            bus.err  <= 1'b1;
                        end
                    end
                    WR_DATA: begin
                        if (wr_armed) begin
                            wr_ptr <= next_ptr(wr_ptr);
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                    RD_ADDR: begin
                        if (in_range) begin
                            rd_ptr   <= payload;
                            rd_armed <= 1'b1;
                        end else begin
                            rd_armed <= 1'b0;
                            bus.err  <= 1'b1;
                        end
                    end
                    RD_DATA: begin
                        if (rd_armed) begin
                            bus.dout     <= mem[rd_ptr];
                            bus.tx_valid <= 1'b1;
                            rd_ptr       <= next_ptr(rd_ptr);
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_ram_param.sv
// Drives one command stream into three RAM configurations and checks each against an array-based reference model.
module tb_spi_ram_param;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid;

    always #5 clk = ~clk;

    spi_ram_param_if #(.ADDR_SIZE(8)) b0 ();
    spi_ram_param_if #(.ADDR_SIZE(8)) b1 ();
    spi_ram_param_if #(.ADDR_SIZE(8)) b2 ();

    assign b0.din = din;
    assign b1.din = din;
    assign b2.din = din;
    assign b0.rx_valid = rx_valid;
    assign b1.rx_valid = rx_valid;
    assign b2.rx_valid = rx_valid;

    spi_ram_param #(.ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    spi_ram_param #(.ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    spi_ram_param #(.ADDR_SIZE(8), .MEM_DEPTH(200), .AUTO_INC(1'b1)) u2 (.clk(clk), .rst(rst), .bus(b2));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-instance memory, pointers and armed flags.
    int         dep [3];
    int         ai  [3];
    logic [7:0] mem [3][256];
    bit         known [3][256];
    int         wp [3];
    int         rp [3];
    bit         wa [3];
    bit         ra [3];
    logic [7:0] e_dout [3];
    bit         e_dk [3];
    bit         e_tx [3];
    bit         e_err [3];
    int         reads_acc = 0;
    int         tx_seen   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            wp[i] = 0; rp[i] = 0; wa[i] = 0; ra[i] = 0;
            e_dout[i] = 8'h00; e_dk[i] = 1; e_tx[i] = 0; e_err[i] = 0;
        end
    endtask

    task automatic model_step(input logic [1:0] c, input int pl, input bit v);
        for (int i = 0; i < 3; i++) begin
            e_tx[i] = 0;
            e_err[i] = 0;
            if (v) begin
                case (c)
                    2'b00: if (pl < dep[i]) begin wp[i] = pl; wa[i] = 1; end
                           else begin wa[i] = 0; e_err[i] = 1; end
                    2'b01: if (wa[i]) begin
                               mem[i][wp[i]] = pl[7:0];
                               known[i][wp[i]] = 1;
                               wp[i] = (wp[i] + ai[i]) % dep[i];
                           end else e_err[i] = 1;
                    2'b10: if (pl < dep[i]) begin rp[i] = pl; ra[i] = 1; end
                           else begin ra[i] = 0; e_err[i] = 1; end
                    default: if (ra[i]) begin
                               e_dout[i] = mem[i][rp[i]];
                               e_dk[i] = known[i][rp[i]];
                               e_tx[i] = 1;
                               rp[i] = (rp[i] + ai[i]) % dep[i];
                               if (i == 1) reads_acc++;
                           end else e_err[i] = 1;
                endcase
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] d;
            logic       t;
            logic       e;
            case (i)
                0:       begin d = b0.dout; t = b0.tx_valid; e = b0.err; end
                1:       begin d = b1.dout; t = b1.tx_valid; e = b1.err; end
                default: begin d = b2.dout; t = b2.tx_valid; e = b2.err; end
            endcase
            chk($sformatf("%s u%0d tx_valid", tag, i), 32'(t), 32'(e_tx[i]));
            chk($sformatf("%s u%0d err", tag, i), 32'(e), 32'(e_err[i]));
            if (e_dk[i]) chk($sformatf("%s u%0d dout", tag, i), 32'(d), 32'(e_dout[i]));
        end
    endtask

    task automatic cyc(input logic [1:0] c, input int pl, input bit v, input string tag);
        @(negedge clk);
        din = {c, pl[7:0]};
        rx_valid = v;
        @(posedge clk);
        model_step(c, pl, v);
        #1;
        if (b1.tx_valid === 1'b1) tx_seen++;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        din = '0;
        rx_valid = 1'b0;
        dep[0] = 256; dep[1] = 256; dep[2] = 200;
        ai[0] = 0;    ai[1] = 1;    ai[2] = 1;
        model_reset();

        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Data commands before any address command are rejected.
        cyc(2'b11, 0, 1, "unarmed rd");
        chk("unarmed rd err", 32'(b0.err), 32'h1);
        cyc(2'b01, 8'h12, 1, "unarmed wr");
        chk("unarmed wr err", 32'(b2.err), 32'h1);

        cyc(2'b00, 8'h10, 1, "basic wa");
        cyc(2'b01, 8'hA5, 1, "basic wd");
        cyc(2'b10, 8'h10, 1, "basic ra");
        cyc(2'b11, 0, 1, "basic rd1");
        chk("basic rd1 dout", 32'(b0.dout), 32'hA5);
        chk("basic rd1 tx", 32'(b0.tx_valid), 32'h1);
        cyc(2'b11, 8'h3C, 1, "basic rd2");
        chk("basic rd2 dout", 32'(b0.dout), 32'hA5);
        cyc(2'b10, 8'h10, 0, "basic idle");
        chk("tx one cycle", 32'(b0.tx_valid), 32'h0);

        cyc(2'b00, 8'hFE, 1, "burst wa");
        cyc(2'b01, 8'h11, 1, "burst wd0");
        cyc(2'b01, 8'h22, 1, "burst wd1");
        cyc(2'b01, 8'h33, 1, "burst wd2");
        cyc(2'b10, 8'hFE, 1, "burst ra");
        cyc(2'b11, 0, 1, "burst rd0");
        chk("burst rd0 dout", 32'(b1.dout), 32'h11);
        cyc(2'b11, 0, 1, "burst rd1");
        chk("burst rd1 dout", 32'(b1.dout), 32'h22);
        cyc(2'b11, 0, 1, "burst rd2");
        chk("burst rd2 dout", 32'(b1.dout), 32'h33);
        chk("burst rd2 tx", 32'(b1.tx_valid), 32'h1);

        cyc(2'b00, 8'hC8, 1, "oor wa");
        chk("oor wa err", 32'(b2.err), 32'h1);
        cyc(2'b01, 8'h77, 1, "oor wd");
        chk("oor wd err", 32'(b2.err), 32'h1);
        cyc(2'b00, 8'hC7, 1, "edge wa");
        cyc(2'b01, 8'h77, 1, "edge wd");
        chk("edge wd no err", 32'(b2.err), 32'h0);
        cyc(2'b10, 8'hC7, 1, "edge ra");
        cyc(2'b11, 0, 1, "edge rd");
        chk("edge rd dout", 32'(b2.dout), 32'h77);

        cyc(2'b00, 8'h20, 1, "gate wa");
        cyc(2'b01, 8'h42, 1, "gate wd");
        cyc(2'b01, 8'h99, 0, "gate idle");
        chk("gate tx", 32'(b0.tx_valid), 32'h0);
        chk("gate err", 32'(b0.err), 32'h0);
        cyc(2'b10, 8'h20, 1, "gate ra");
        cyc(2'b11, 0, 1, "gate rd");
        chk("gate rd dout", 32'(b1.dout), 32'h42);

        cyc(2'b00, 8'h50, 1, "raw wa");
        cyc(2'b10, 8'h50, 1, "raw ra");
        cyc(2'b01, 8'hC3, 1, "raw wd");
        cyc(2'b11, 0, 1, "raw rd");
        chk("raw rd dout", 32'(b0.dout), 32'hC3);

        // Asynchronous reset while a read response is on the bus.
        cyc(2'b00, 8'h30, 1, "rst wa");
        cyc(2'b01, 8'h5A, 1, "rst wd");
        cyc(2'b10, 8'h30, 1, "rst ra");
        cyc(2'b11, 0, 1, "rst rd");
        chk("pre-rst dout", 32'(b0.dout), 32'h5A);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async rst dout", 32'(b0.dout), 32'h00);
        chk("async rst tx", 32'(b1.tx_valid), 32'h0);
        check_all("async rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(2'b11, 0, 1, "post-rst rd");
        chk("post-rst rd err", 32'(b0.err), 32'h1);
        chk("post-rst rd tx", 32'(b0.tx_valid), 32'h0);
        cyc(2'b10, 8'h30, 1, "retain ra");
        cyc(2'b11, 0, 1, "retain rd");
        chk("retained dout", 32'(b2.dout), 32'h5A);

        for (int k = 0; k < 600; k++) begin
            cyc(2'($urandom_range(0, 3)), int'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0), "rand");
        end
        chk("u1 tx pulse count", 32'(tx_seen), 32'(reads_acc));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
